alu_writeback_stage: RTL

//  Execute/write-back stage directly downstream of the 8x16 two-read/one-write register file.

---
 rtl/alu_writeback_stage_pkg.sv | 28 ++
 rtl/alu_writeback_stage_multiplier.sv | 50 +++++
 rtl/alu_writeback_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and sizing for the execute/write-back stage and its register file.
package regfile_pkg;

   localparam int unsigned BIT_WIDTH        = 16;
   localparam int unsigned NUMBER_REGISTERS = 8;
   localparam int unsigned REGISTER_SELECT  = $clog2(NUMBER_REGISTERS);

   typedef logic [BIT_WIDTH-1:0]       word_t;
   typedef logic [REGISTER_SELECT-1:0] reg_addr_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MUL
   } ex_state_e;

endpackage

// File: rtl/alu_writeback_stage_multiplier.sv
// Iterative shift-add multiplier: one partial product per step, low BIT_WIDTH bits kept.
module shift_add_multiplier #(
   parameter int unsigned BIT_WIDTH = regfile_pkg::BIT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 step,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   output logic [BIT_WIDTH-1:0] product,
   output logic                 done
);

   localparam int unsigned CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

   logic [BIT_WIDTH-1:0] mcand;
   logic [BIT_WIDTH-1:0] mplier;
   logic [BIT_WIDTH-1:0] acc;
   logic [BIT_WIDTH-1:0] acc_next;
   logic [CW-1:0]        count;

   // product includes the step in progress, so the final step's result is usable in the same cycle
   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign product  = acc_next;
   assign done     = (count == '0);

   // load operands on start, then advance one multiplier bit per step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= CW'(BIT_WIDTH - 1);
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (count != '0) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/write-back stage: operand bypass, ALU / iterative MUL, registered write port.
module alu_writeback_stage
   import regfile_pkg::*;
#(
   parameter int unsigned BIT_WIDTH        = regfile_pkg::BIT_WIDTH,
   parameter int unsigned NUMBER_REGISTERS = regfile_pkg::NUMBER_REGISTERS,
   parameter int unsigned REGISTER_SELECT  = $clog2(NUMBER_REGISTERS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_op,
   input  logic [REGISTER_SELECT-1:0] in_rd,
   input  logic [REGISTER_SELECT-1:0] in_ra,
   input  logic [REGISTER_SELECT-1:0] in_rb,
   output logic [REGISTER_SELECT-1:0] rf_src_a,
   output logic [REGISTER_SELECT-1:0] rf_src_b,
   input  logic [BIT_WIDTH-1:0]       rf_data_a,
   input  logic [BIT_WIDTH-1:0]       rf_data_b,
   output logic                       rf_we,
   output logic [REGISTER_SELECT-1:0] rf_wdst,
   output logic [BIT_WIDTH-1:0]       rf_wdata,
   output logic                       wb_zero,
   output logic                       busy
);

   ex_state_e                  state;
   alu_op_e                    ex_op;
   logic [REGISTER_SELECT-1:0] ex_rd;
   logic [BIT_WIDTH-1:0]       ex_a;
   logic [BIT_WIDTH-1:0]       ex_b;
   logic [BIT_WIDTH-1:0]       alu_result;
   logic [BIT_WIDTH-1:0]       opnd_a;
   logic [BIT_WIDTH-1:0]       opnd_b;
   logic [BIT_WIDTH-1:0]       mul_product;
   logic                       mul_done;
   alu_op_e                    in_op_e;
   logic                       accept;
   logic                       mul_start;

   assign in_op_e   = alu_op_e'(in_op);
   assign in_ready  = (state != MUL);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (in_op_e == OP_MUL);
   assign rf_src_a  = in_ra;
   assign rf_src_b  = in_rb;
   assign wb_zero   = rf_we && (rf_wdata == '0);
   assign busy      = (state != IDLE) || rf_we;

   shift_add_multiplier #(
      .BIT_WIDTH (BIT_WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .step    (state == MUL),
      .a       (opnd_a),
      .b       (opnd_b),
      .product (mul_product),
      .done    (mul_done)
   );

   // single-cycle ALU on the latched EX operands; MUL is produced by the multiplier instead
   always_comb begin
      alu_result = '0;
      unique case (ex_op)
         OP_ADD:  alu_result = ex_a + ex_b;
         OP_SUB:  alu_result = ex_a - ex_b;
         OP_AND:  alu_result = ex_a & ex_b;
         OP_OR:   alu_result = ex_a | ex_b;
         OP_XOR:  alu_result = ex_a ^ ex_b;
         OP_SHL:  alu_result = ex_a << ex_b[3:0];
         OP_SHR:  alu_result = ex_a >> ex_b[3:0];
         default: alu_result = '0;
      endcase
   end

   // operand bypass: in-flight EX result first, then the pending write-back, then the file
   always_comb begin
      opnd_a = rf_data_a;
      opnd_b = rf_data_b;
      if ((state == EXEC) && (ex_rd == in_ra)) begin
         opnd_a = alu_result;
      end else if (rf_we && (rf_wdst == in_ra)) begin
         opnd_a = rf_wdata;
      end
      if ((state == EXEC) && (ex_rd == in_rb)) begin
         opnd_b = alu_result;
      end else if (rf_we && (rf_wdst == in_rb)) begin
         opnd_b = rf_wdata;
      end
   end

   // EX FSM and operand latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ex_op <= OP_ADD;
         ex_rd <= '0;
         ex_a  <= '0;
         ex_b  <= '0;
      end else begin
         unique case (state)
            IDLE, EXEC: begin
               if (accept) begin
                  ex_op <= in_op_e;
                  ex_rd <= in_rd;
                  ex_a  <= opnd_a;
                  ex_b  <= opnd_b;
                  state <= (in_op_e == OP_MUL) ? MUL : EXEC;
               end else begin
                  state <= IDLE;
               end
            end
            MUL: begin
               if (mul_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // write-back register: one-cycle write strobe per completed op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_wdst  <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= 1'b0;
         if (state == EXEC) begin
            rf_we    <= 1'b1;
            rf_wdst  <= ex_rd;
            rf_wdata <= alu_result;
         end else if ((state == MUL) && mul_done) begin
            rf_we    <= 1'b1;
            rf_wdst  <= ex_rd;
            rf_wdata <= mul_product;
         end
      end
   end

endmodule
